// File: rtl/golden_nonce_tx_if.sv
// Nonce push / UART TX bundle for golden_nonce_tx: the miner core drives the push side
// and the transmitter drives the line and status.
interface golden_nonce_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      golden_nonce;
  logic             new_golden_nonce;
  logic             clear_overflow;
  logic             tx_serial;
  logic             tx_busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output golden_nonce, new_golden_nonce, clear_overflow,
    input  tx_serial, tx_busy, fifo_count, overflow
  );

  modport slave (
    input  golden_nonce, new_golden_nonce, clear_overflow,
    output tx_serial, tx_busy, fifo_count, overflow
  );
endinterface

// File: rtl/golden_nonce_tx.sv
// Golden-nonce queue plus 8N1 packet serialiser: 0x4E header, then nonce MSB byte first.
// Define GOLDEN_NONCE_TX_CHECKSUM_EN to append an XOR checksum byte to every packet.
module golden_nonce_tx #(
  parameter int baud_rate    = 9600,
  parameter int sys_clk_freq = 12000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              comm_clk,
  input  logic              reset_n,
  golden_nonce_tx_if.slave  bus
);
  localparam int CPB   = sys_clk_freq / baud_rate;
  localparam int BW    = $clog2(CPB);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [7:0] HDR = 8'h4E;
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       byte_q, byte_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_q [FIFO_DEPTH];

  logic        pop, push, drop, full, baud_last;
  logic [31:0] head;

  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [31:0] n);
    case (idx)
      3'd1:    pkt_byte = n[31:24];
      3'd2:    pkt_byte = n[23:16];
      3'd3:    pkt_byte = n[15:8];
      3'd4:    pkt_byte = n[7:0];
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
      3'd5:    pkt_byte = HDR ^ n[31:24] ^ n[23:16] ^ n[15:8] ^ n[7:0];
`endif
      default: pkt_byte = HDR;
    endcase
  endfunction

  assign head      = mem_q[rd_ptr_q];
  assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign baud_last = (baud_q == BW'(CPB - 1));

  // A pop on the same edge frees a slot, so a push into a full FIFO is accepted then.
  always_comb begin
    push     = bus.new_golden_nonce && (!full || pop);
    drop     = bus.new_golden_nonce && full && !pop;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = drop ? 1'b1 : (bus.clear_overflow ? 1'b0 : ovf_q);
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    byte_d     = byte_q;
    shadow_d   = shadow_q;
    pop        = 1'b0;
    if (state_q != IDLE) baud_d = baud_last ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop        = 1'b1;
        shadow_d   = head;
        byte_d     = HDR;
        byte_idx_d = 3'd0;
        baud_d     = '0;
        state_d    = START;
      end
      START: if (baud_last) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
      end
      DATA: if (baud_last) begin
        if (bit_idx_q == 3'd7) state_d = STOP;
        else                   bit_idx_d = bit_idx_q + 3'd1;
      end
      STOP: if (baud_last) begin
        if (byte_idx_q != LAST_BYTE) begin
          byte_idx_d = byte_idx_q + 3'd1;
          byte_d     = pkt_byte(byte_idx_q + 3'd1, shadow_q);
          state_d    = START;
        end else if (cnt_q != '0) begin
          // back-to-back packet: no idle bit between the stop bit and the next header
          pop        = 1'b1;
          shadow_d   = head;
          byte_d     = HDR;
          byte_idx_d = 3'd0;
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // line and busy are registered from next-state so the pin never glitches
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge comm_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      byte_q     <= '0;
      shadow_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      byte_q     <= byte_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge comm_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.golden_nonce;
  end

  assign bus.tx_serial  = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.fifo_count = cnt_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_golden_nonce_tx.sv
// Bench for golden_nonce_tx: random nonces checked every clock against a queue + packet-timer model.
module tb_golden_nonce_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef GOLDEN_NONCE_TX_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int PKT = NB * 10 * CPB;

  logic comm_clk = 1'b0;
  logic reset_n  = 1'b0;
  always #5 comm_clk = ~comm_clk;

  golden_nonce_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  golden_nonce_tx #(.baud_rate(1), .sys_clk_freq(4), .FIFO_DEPTH(DEPTH)) dut (
    .comm_clk (comm_clk),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  // Model: pending nonces, the nonce on the wire, and clocks left in its packet.
  logic [31:0] mq[$];
  logic [31:0] cur;
  int          rem;
  logic        movf;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] exp_byte(input int bi);
    if (bi == 0) return 8'h4E;
    if (bi <= 4) return 8'(cur >> (8 * (4 - bi)));
    return 8'h4E ^ cur[31:24] ^ cur[23:16] ^ cur[15:8] ^ cur[7:0];
  endfunction

  function automatic logic exp_line();
    int p, slot;
    logic [7:0] b;
    if (rem == 0) return 1'b1;
    p    = PKT - rem;
    slot = (p % (10 * CPB)) / CPB;
    b    = exp_byte(p / (10 * CPB));
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_tx"},    32'(bus.tx_serial),  32'(exp_line()));
    chk({tag, "_busy"},  32'(bus.tx_busy),    32'(rem > 0));
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'(mq.size()));
    chk({tag, "_ovf"},   32'(bus.overflow),   32'(movf));
  endtask

  task automatic model_edge(input logic p, input logic [31:0] v, input logic c);
    if (rem <= 1 && mq.size() > 0) begin
      cur = mq.pop_front();
      rem = PKT;
    end else if (rem > 0) begin
      rem--;
    end
    if (p && mq.size() >= DEPTH) movf = 1'b1;
    else begin
      if (p) mq.push_back(v);
      if (c) movf = 1'b0;
    end
  endtask

  task automatic cyc(input logic p, input logic [31:0] v, input logic c, input string tag);
    bus.new_golden_nonce = p;
    bus.golden_nonce     = v;
    bus.clear_overflow   = c;
    @(posedge comm_clk);
    model_edge(p, v, c);
    #1;
    bus.new_golden_nonce = 1'b0;
    bus.clear_overflow   = 1'b0;
    check_outs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, tag);
  endtask

  // Advance until the model's packet timer reaches target; an expired bound is a failure.
  task automatic wait_rem(input int target, input string tag);
    int g = 0;
    while (rem != target && g < 3 * PKT) begin
      cyc(1'b0, 32'h0, 1'b0, tag);
      g++;
    end
    if (rem != target) begin
      errors++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, rem, target);
    end
  endtask

  initial begin
    bus.golden_nonce     = '0;
    bus.new_golden_nonce = 1'b0;
    bus.clear_overflow   = 1'b0;
    mq.delete(); rem = 0; movf = 1'b0; cur = '0;
    #12;
    check_outs("reset");
    reset_n = 1'b1;

    // single known nonce, then a random one
    cyc(1'b1, 32'h12345678, 1'b0, "single_push");
    chk("latency_idle_tx", 32'(bus.tx_serial), 32'd1);
    cyc(1'b0, 32'h0, 1'b0, "single_pop");
    chk("latency_start_tx", 32'(bus.tx_serial), 32'd0);
    chk("latency_busy", 32'(bus.tx_busy), 32'd1);
    idle(PKT + 8, "single");
    cyc(1'b1, $urandom, 1'b0, "rand_single");
    idle(PKT + 8, "rand_single");

    // burst of six from idle: one popped, four queued, one dropped
    for (int i = 0; i < 6; i++) cyc(1'b1, $urandom, 1'b0, "burst");
    chk("burst_count", 32'(bus.fifo_count), 32'd4);
    chk("burst_ovf", 32'(bus.overflow), 32'd1);
    idle(5 * PKT + 8, "burst_drain");
    cyc(1'b0, 32'h0, 1'b1, "ovf_clear");
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // drop and clear on the same edge: set wins
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, "fill");
    cyc(1'b1, $urandom, 1'b1, "drop_clr");
    chk("drop_clr_ovf", 32'(bus.overflow), 32'd1);
    cyc(1'b0, 32'h0, 1'b1, "clr2");

    // push on the pop edge while full
    wait_rem(1, "pop_edge");
    cyc(1'b1, $urandom, 1'b0, "full_pushpop");
    chk("full_pushpop_count", 32'(bus.fifo_count), 32'd4);
    chk("full_pushpop_ovf", 32'(bus.overflow), 32'd0);
    idle(5 * PKT + 8, "full_drain");

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 59) == 0, $urandom, $urandom_range(0, 149) == 0, "random");
    idle(5 * PKT + 8, "random_drain");

    // reset during DATA of byte 2 with two entries queued
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, 1'b0, "pre_rst");
    wait_rem(PKT - (2 * 10 * CPB + 4 * CPB + 1), "to_byte2");
    chk("pre_rst_count", 32'(bus.fifo_count), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    mq.delete(); rem = 0; movf = 1'b0;
    check_outs("rst_mid");
    #2 reset_n = 1'b1;
    idle(60, "post_rst_idle");
    cyc(1'b1, $urandom, 1'b0, "post_rst_push");
    idle(PKT + 8, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
